// File: rtl/mfp_ahb_ram_slave_ws.sv
// AHB-Lite on-chip RAM slave with programmable wait states, HSIZE-based
// byte/halfword lane writes (endian selectable) and read-after-write forwarding.
// Optional build macro: MFP_AHB_RAM_ERROR_RESP_EN adds a two-cycle ERROR
// response for oversized or misaligned transfers.
module mfp_ahb_ram_slave_ws #(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [3:0]  HPROT,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    input  logic        SI_Endian
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

`ifdef MFP_AHB_RAM_ERROR_RESP_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t                state, state_nx;
    logic [2:0]            cnt, cnt_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            mask_q;
    logic                  write_q;

    logic [31:0]           mem [0:DEPTH-1];

    logic                  accept;
    logic                  err_d;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [3:0]            mask_d;
    logic                  rd_load;
    logic [31:0]           rd_word;

    // Bursts, locking, protection and aliased address bits have no effect here.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // Byte lanes touched by an access; sizes above word behave as word and
    // misaligned half/word accesses fall back to their natural alignment.
    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] a,
                                             input logic       be);
        logic [1:0] lane;
        lane      = be ? ~a : a;
        lane_mask = 4'b1111;
        case (size)
            3'd0:    lane_mask = 4'b0001 << lane;
            3'd1:    lane_mask = (a[1] ^ be) ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Replace the masked byte lanes of a stored word with new write data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  m);
        merge_lanes = old_w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

    assign accept = HSEL && HTRANS[1] && HREADY;
    assign addr_d = HADDR[ADDR_WIDTH+1:2];
    assign mask_d = lane_mask(HSIZE, HADDR[1:0], SI_Endian);
    assign commit = (state == S_DATA) && write_q;

`ifdef MFP_AHB_RAM_ERROR_RESP_EN
    assign err_d  = (HSIZE > 3'd2) ||
                    ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign HREADY = (state != S_WAIT) && (state != S_ERR1);
    assign HRESP  = (state == S_ERR1) || (state == S_ERR2);
`else
    assign err_d  = 1'b0;
    assign HREADY = (state != S_WAIT);
    assign HRESP  = 1'b0;
`endif

    // Next-state and wait-counter logic; any HREADY-high state may take a new transfer.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_WAIT: begin
                if (cnt == 3'd0) state_nx = S_DATA;
                else             cnt_nx   = cnt - 3'd1;
            end
`ifdef MFP_AHB_RAM_ERROR_RESP_EN
            S_ERR1: state_nx = S_ERR2;
`endif
            default: begin
                state_nx = S_IDLE;
                if (accept) begin
`ifdef MFP_AHB_RAM_ERROR_RESP_EN
                    if (err_d) begin
                        state_nx = S_ERR1;
                    end else
`endif
                    if (WAIT_STATES > 0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = WS_LOAD;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
        endcase
    end

    // Control state: FSM, wait counter and pending-write flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) write_q <= HWRITE && !err_d;
        end
    end

    // Address-phase capture of the target word and its byte lanes.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_q <= addr_d;
            mask_q <= mask_d;
        end
    end

    // Lane-masked write commit at the end of a write data phase; reset abandons it.
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Read word selection: zero-wait reads are fetched at acceptance and merge a
    // write committing at that same edge; waited reads fetch after the write landed.
    always_comb begin
        rd_load = 1'b0;
        rd_word = mem[addr_q];
        if (WAIT_STATES == 0) begin
            rd_load = accept && !HWRITE && !err_d;
            rd_word = mem[addr_d];
            if (commit && (addr_q == addr_d)) rd_word = merge_lanes(mem[addr_d], HWDATA, mask_q);
        end else begin
            rd_load = (state == S_WAIT) && (cnt == 3'd0) && !write_q;
        end
    end

    // Read data register, updated only when a read's data becomes available.
    always_ff @(posedge HCLK) begin
        if (HRESET)       HRDATA <= 32'd0;
        else if (rd_load) HRDATA <= rd_word;
    end

endmodule

// File: tb/tb_mfp_ahb_ram_slave_ws.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) on a shared bus,
// one selected at a time, checked against a word-array memory model.
module tb_mfp_ahb_ram_slave_ws;

    localparam int NW = 16;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HWRITE, SI_Endian;
    logic        hsel;
    int          sel;

    logic [2:0]  ready, resp;
    logic [31:0] rd0, rd1, rd2;
    logic        hs0, hs1, hs2;

    int          ws_of [3] = '{0, 2, 3};
    logic [31:0] mem_m [3][NW];

    int checks   = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    assign hs0 = hsel && (sel == 0);
    assign hs1 = hsel && (sel == 1);
    assign hs2 = hsel && (sel == 2);

    mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(6), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(hs0), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(rd0),
        .HREADY(ready[0]), .HRESP(resp[0]), .SI_Endian(SI_Endian));

    mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(6), .WAIT_STATES(2)) u_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(hs1), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(rd1),
        .HREADY(ready[1]), .HRESP(resp[1]), .SI_Endian(SI_Endian));

    mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(6), .WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(hs2), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(rd2),
        .HREADY(ready[2]), .HRESP(resp[2]), .SI_Endian(SI_Endian));

    function automatic logic [31:0] rdata_of(input int k);
        case (k)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    // Lanes written by an access, straight from the lane-mapping rules.
    function automatic logic [3:0] ref_lanes(input int size, input logic [1:0] a, input logic be);
        int lane;
        if (size == 0) begin
            lane = be ? (3 - int'(a)) : int'(a);
            return 4'(1 << lane);
        end
        if (size == 1) begin
            if (!be) return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
            return (a[1] == 1'b0) ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int idx, input logic [1:0] low);
        logic [31:0] t;
        t = $urandom;
        return {t[31:8], 6'(idx), low};
    endfunction

    // One isolated transfer: address phase, then data phase until HREADY.
    task automatic bus_op(input int k, input logic wr, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic be,
                          output logic [31:0] rd, output int waits,
                          output logic rsp_first, output logic rsp_last, output logic ok);
        int g;
        @(posedge HCLK); #1;
        sel = k; hsel = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz; SI_Endian = be;
        @(posedge HCLK); #1;
        hsel = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        HADDR = $urandom; HSIZE = 3'($urandom); SI_Endian = 1'($urandom);
        waits = 0; ok = 1'b1;
        @(negedge HCLK);
        rsp_first = resp[k];
        g = 0;
        while (!ready[k] && g < 20) begin
            waits++; g++;
            @(negedge HCLK);
        end
        if (g >= 20) ok = 1'b0;
        rd = rdata_of(k);
        rsp_last = resp[k];
    endtask

    // Write immediately followed by a pipelined word read of the same word.
    task automatic b2b(input int k, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic be,
                       output logic [31:0] rd, output int ww, output int rw, output logic ok);
        int g;
        ok = 1'b1; ww = 0; rw = 0;
        @(posedge HCLK); #1;
        sel = k; hsel = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1; HSIZE = sz; SI_Endian = be;
        @(posedge HCLK); #1;
        HWDATA = wd; HADDR = {a[31:2], 2'b00} ^ 32'hA5A0_0000; HWRITE = 1'b0; HSIZE = 3'd2;
        HTRANS = 2'b10; SI_Endian = 1'($urandom);
        @(negedge HCLK);
        g = 0;
        while (!ready[k] && g < 20) begin ww++; g++; @(negedge HCLK); end
        if (g >= 20) ok = 1'b0;
        @(posedge HCLK); #1;
        hsel = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        g = 0;
        while (!ready[k] && g < 20) begin rw++; g++; @(negedge HCLK); end
        if (g >= 20) ok = 1'b0;
        rd = rdata_of(k);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; hsel = 1'b0; sel = 0; HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
        HBURST = '0; HSIZE = 3'd2; HMASTLOCK = 1'b0; HPROT = '0; HWRITE = 1'b0; SI_Endian = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ready[k] !== 1'b1) begin failures++; $display("FAIL reset_hready inst=%0d got=%b exp=1", k, ready[k]); end
            checks++;
            if (resp[k] !== 1'b0) begin failures++; $display("FAIL reset_hresp inst=%0d got=%b exp=0", k, resp[k]); end
            checks++;
            if (rdata_of(k) !== 32'd0) begin failures++; $display("FAIL reset_hrdata inst=%0d got=%h exp=0", k, rdata_of(k)); end
        end
    endtask

    task automatic test_init();
        logic [31:0] rd, d; int w; logic r1, r2, ok;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NW; i++) begin
                d = $urandom;
                bus_op(k, 1'b1, 3'd2, mk_addr(i, 2'b00), d, 1'b0, rd, w, r1, r2, ok);
                mem_m[k][i] = d;
                checks++;
                if (!ok || w != ws_of[k]) begin failures++; $display("FAIL init_waits inst=%0d got=%0d exp=%0d", k, w, ws_of[k]); end
            end
        end
    endtask

    task automatic test_ws0();
        logic [31:0] rd; int w; logic r1, r2, ok;
        bus_op(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd, w, r1, r2, ok);
        mem_m[0][4] = 32'hDEADBEEF;
        checks++;
        if (!ok || w != 0) begin failures++; $display("FAIL ws0_write_waits got=%0d exp=0", w); end
        bus_op(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || w != 0) begin failures++; $display("FAIL ws0_read_waits got=%0d exp=0", w); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ws0_read_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_ws3();
        logic [31:0] rd; int w; logic r1, r2, ok;
        bus_op(2, 1'b0, 3'd2, 32'h4, 32'h0, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || w != 3) begin failures++; $display("FAIL ws3_read_waits got=%0d exp=3", w); end
        checks++;
        if (rd !== mem_m[2][1]) begin failures++; $display("FAIL ws3_read_data got=%h exp=%h", rd, mem_m[2][1]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int w; logic r1, r2, ok;
        logic [31:0] exp_v [2] = '{32'h1122AA44, 32'h11AA3344};
        for (int be = 0; be < 2; be++) begin
            bus_op(0, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, rd, w, r1, r2, ok);
            bus_op(0, 1'b1, 3'd0, 32'h21, 32'hAAAAAAAA, 1'(be), rd, w, r1, r2, ok);
            bus_op(0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, rd, w, r1, r2, ok);
            mem_m[0][8] = exp_v[be];
            checks++;
            if (!ok || rd !== exp_v[be]) begin failures++; $display("FAIL byte_lane be=%0d got=%h exp=%h", be, rd, exp_v[be]); end
        end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd; int w; logic r1, r2, ok;
        @(posedge HCLK); #1;
        sel = 0; hsel = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'hC; HWDATA = ~mem_m[0][3];
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (ready[0] !== 1'b1 || resp[0] !== 1'b0) begin
                failures++; $display("FAIL busy_okay got_ready=%b got_resp=%b exp=1/0", ready[0], resp[0]);
            end
            if (i == 1) HTRANS = 2'b00;
        end
        bus_op(0, 1'b0, 3'd2, 32'hC, 32'h0, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || rd !== mem_m[0][3]) begin failures++; $display("FAIL busy_no_write got=%h exp=%h", rd, mem_m[0][3]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, wd, a; int ww, rw, k, idx, sz; logic ok, be;
        int ks [2] = '{0, 2};
        for (int j = 0; j < 2; j++) begin
            b2b(ks[j], 3'd2, 32'h8, 32'hCAFEF00D, 1'b0, rd, ww, rw, ok);
            mem_m[ks[j]][2] = 32'hCAFEF00D;
            checks++;
            if (!ok || rd !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_fixed inst=%0d got=%h exp=cafef00d", ks[j], rd); end
        end
        for (int n = 0; n < 12; n++) begin
            k = $urandom_range(0, 2); idx = $urandom_range(0, NW - 1);
            sz = $urandom_range(0, 2); be = 1'($urandom); wd = $urandom;
            a = mk_addr(idx, (sz == 0) ? 2'($urandom) : (sz == 1) ? {1'($urandom), 1'b0} : 2'b00);
            b2b(k, 3'(sz), a, wd, be, rd, ww, rw, ok);
            mem_m[k][idx] = ref_merge(mem_m[k][idx], wd, ref_lanes(sz, a[1:0], be));
            checks++;
            if (!ok || ww != ws_of[k] || rw != ws_of[k] || rd !== mem_m[k][idx]) begin
                failures++;
                $display("FAIL b2b_rand inst=%0d got=%h exp=%h waits=%0d/%0d exp_waits=%0d", k, rd, mem_m[k][idx], ww, rw, ws_of[k]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; int w; logic r1, r2, ok;
        bus_op(1, 1'b1, 3'd2, 32'h14, 32'h12345678, 1'b0, rd, w, r1, r2, ok);
        mem_m[1][5] = 32'h12345678;
        @(posedge HCLK); #1;
        sel = 1; hsel = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        hsel = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        checks++;
        if (ready[1] !== 1'b0) begin failures++; $display("FAIL rst_mid_wait got=%b exp=0", ready[1]); end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++;
        if (ready[1] !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready[1]); end
        repeat (3) @(posedge HCLK);
        bus_op(1, 1'b0, 3'd2, 32'h14, 32'h0, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || rd !== 32'h12345678) begin failures++; $display("FAIL rst_mid_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; int w; logic r1, r2, ok;
`ifdef MFP_AHB_RAM_ERROR_RESP_EN
        bus_op(2, 1'b1, 3'd2, 32'h2, 32'h5A5A1234, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || w != 1) begin failures++; $display("FAIL err_waits got=%0d exp=1", w); end
        checks++;
        if (r1 !== 1'b1 || r2 !== 1'b1) begin failures++; $display("FAIL err_resp got=%b%b exp=11", r1, r2); end
        bus_op(2, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || rd !== mem_m[2][0] || r2 !== 1'b0) begin failures++; $display("FAIL err_nowrite got=%h exp=%h resp=%b", rd, mem_m[2][0], r2); end
`else
        bus_op(2, 1'b1, 3'd2, 32'h2, 32'h5A5A1234, 1'b0, rd, w, r1, r2, ok);
        mem_m[2][0] = 32'h5A5A1234;
        checks++;
        if (!ok || w != 3 || r2 !== 1'b0) begin failures++; $display("FAIL misalign_write waits=%0d resp=%b exp=3/0", w, r2); end
        bus_op(2, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, rd, w, r1, r2, ok);
        checks++;
        if (!ok || rd !== 32'h5A5A1234) begin failures++; $display("FAIL misalign_data got=%h exp=5a5a1234", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, a; int w, k, idx, sz; logic r1, r2, ok, be, wr; logic [1:0] low;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 2); idx = $urandom_range(0, NW - 1);
            wr = 1'($urandom); be = 1'($urandom); wd = $urandom; low = 2'($urandom);
`ifdef MFP_AHB_RAM_ERROR_RESP_EN
            sz = $urandom_range(0, 2);
            if (sz == 1) low[0] = 1'b0;
            if (sz == 2) low = 2'b00;
`else
            sz = $urandom_range(0, 3);
`endif
            a = mk_addr(idx, low);
            bus_op(k, wr, 3'(sz), a, wd, be, rd, w, r1, r2, ok);
            checks++;
            if (!ok || w != ws_of[k] || r2 !== 1'b0) begin
                failures++; $display("FAIL rand_waits inst=%0d got=%0d exp=%0d resp=%b", k, w, ws_of[k], r2);
            end
            if (wr) begin
                mem_m[k][idx] = ref_merge(mem_m[k][idx], wd, ref_lanes(sz, low, be));
            end else begin
                checks++;
                if (rd !== mem_m[k][idx]) begin failures++; $display("FAIL rand_read inst=%0d idx=%0d got=%h exp=%h", k, idx, rd, mem_m[k][idx]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_ws0();
        test_ws3();
        test_byte_lanes();
        test_idle_busy();
        test_back_to_back();
        test_reset_mid_write();
        test_misaligned();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_ram_slave_ws.md
Name: mfp_ahb_ram_slave_ws

Overview:
Parametrised AHB-Lite on-chip RAM slave, successor to the fixed zero-wait word RAM slave. Adds programmable wait states, HSIZE-based byte/halfword writes with endian-selectable lane mapping, and read-after-write forwarding. It sits on the AHB-Lite interconnect behind the address decoder as a general-purpose data/boot RAM.

Parameters:
ADDR_WIDTH, 6, word-address width; depth = 2**ADDR_WIDTH 32-bit words; HADDR[ADDR_WIDTH+1:2] selects the word, upper bits alias.
WAIT_STATES, 0, data-phase wait cycles per transfer (0..7); 3-bit internal counter.

Ports:
HCLK  input  1  bus clock; all logic on rising edge
HRESET  input  1  synchronous, active-high reset
HADDR  input  32  address-phase address
HBURST  input  3  ignored (bursts handled as single transfers)
HMASTLOCK  input  1  ignored
HPROT  input  4  ignored
HSEL  input  1  slave select
HSIZE  input  3  0=byte, 1=half, 2=word
HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ
HWDATA  input  32  write data, valid during the data phase
HWRITE  input  1  1=write
HRDATA  output  32  read data, valid when HREADY=1 in a read data phase
HREADY  output  1  transfer done / slave ready
HRESP  output  1  0=OKAY, 1=ERROR
SI_Endian  input  1  0=little-endian, 1=big-endian lane mapping

Behaviour:
- Reset (HRESET=1 at an edge): HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, no pending write. RAM contents are not cleared. A transfer in flight when reset asserts is abandoned and its write is not committed.
- Address phase is accepted at an edge where HSEL=1, HTRANS[1]=1 and HREADY=1. The slave registers word address, lane mask, HWRITE and HSIZE.
- FSM states: IDLE, WAIT, DATA (plus ERR1/ERR2 with the optional feature).
  - IDLE -> WAIT on an accepted transfer when WAIT_STATES>0; IDLE -> DATA when WAIT_STATES=0.
  - WAIT: HREADY=0; counter loads WAIT_STATES-1 and decrements; at 0 -> DATA.
  - DATA: HREADY=1. Accepting a new transfer in the same cycle re-enters WAIT or DATA; otherwise -> IDLE.
- Read latency: HRDATA is valid in the first HREADY=1 data-phase cycle, i.e. WAIT_STATES+1 cycles after address acceptance. HRDATA holds its last value otherwise.
- Write commit: at the edge ending the data phase (HREADY=1), only the masked lanes of HWDATA are written.
- Lane mask, little-endian (SI_Endian=0):
  - byte: lane HADDR[1:0]
  - half: lanes {1,0} if HADDR[1]=0, else {3,2}
  - word: all four lanes
- Lane mask, big-endian (SI_Endian=1): byte lane = 3-HADDR[1:0]; half = {3,2} if HADDR[1]=0, else {1,0}. SI_Endian is sampled at the address phase.
- HSIZE>2: treated as word (feature off). Misaligned half/word: the address is forced down to its natural alignment (feature off).
- Read-after-write forwarding: if a read is accepted to the same word during a pending write's data phase, the read returns the word with the written lanes merged. Stale data is never returned.
- Simultaneous write commit and new address acceptance are both processed in the same cycle.
- HTRANS IDLE/BUSY with HSEL=1: OKAY response, zero wait, no RAM access.

Optional Feature:
MFP_AHB_RAM_ERROR_RESP_EN.
- Defined: HSIZE>2 or a misaligned access (half with HADDR[0]=1; word with HADDR[1:0]!=0) gets a two-cycle AHB ERROR response.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
  - No wait states are inserted and no write is committed; ERR2 may accept the next transfer.
- Undefined: ERR states do not exist, HRESP is tied to 0, and the alignment/size rules under Behaviour apply.

Test Plan:
- Reset: HRESET=1 for 2 cycles, then 0 -> HREADY=1, HRESP=0, HRDATA=0.
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> HREADY stays 1; HRDATA=0xDEADBEEF one cycle after read address acceptance.
- WAIT_STATES=3: read @0x4 -> HREADY low exactly 3 cycles, then high with correct data.
- Byte writes: SI_Endian=0, byte 0xAA @0x21 over 0x11223344 -> 0x1122AA44. SI_Endian=1, same access -> 0x11AA3344.
- Back-to-back: word write 0xCAFEF00D @0x8 followed by a pipelined read @0x8 -> read returns 0xCAFEF00D (forwarding). Reset asserted during a WAIT_STATES=2 write -> word unchanged.
- With MFP_AHB_RAM_ERROR_RESP_EN: word write @0x2 -> HRESP=1 for 2 cycles, HREADY 0 then 1, memory unchanged. Without the macro: same access writes word @0x0.
